// File: rtl/apb_ucpd_tx_sched_pkg.sv
// Shared definitions for the UCPD transmit scheduler: state encoding, counter width,
// ordered-set bit counts, and helpers that tell which request a state currently owns.
package apb_ucpd_tx_sched_pkg;

  localparam int SCHED_CNT_W = 5;

  // Encoded (4b5b) bit lengths of the preamble, SOP ordered set and CRC field
  localparam int PRE_BIT_CNT = 64;
  localparam int SOP_BIT_CNT = 20;
  localparam int CRC_BIT_CNT = 40;

  typedef enum logic [2:0] {
    SCHED_IDLE = 3'd0,
    SCHED_WIN  = 3'd1,
    SCHED_MSG  = 3'd2,
    SCHED_HRST = 3'd3,
    SCHED_GAP  = 3'd4
  } sched_state_e;

  function automatic logic msg_owned(sched_state_e st, logic hrst_pend);
    return ((st == SCHED_WIN) && !hrst_pend) || (st == SCHED_MSG);
  endfunction

  function automatic logic hrst_owned(sched_state_e st, logic hrst_pend);
    return hrst_pend || (st == SCHED_HRST);
  endfunction

endpackage

// File: rtl/apb_ucpd_tx_sched_if.sv
// Handshake between the transmit scheduler (master) and the PD main TX state machine (slave).
interface apb_ucpd_tx_sched_if;

  logic transmit_en;
  logic tx_hrst;
  logic transwin_en;
  logic ifrgap_en;
  logic tx_busy;
  logic tx_eop_cmplt;
  logic tx_sop_rst_cmplt;

  modport master (
    output transmit_en, tx_hrst, transwin_en, ifrgap_en,
    input  tx_busy, tx_eop_cmplt, tx_sop_rst_cmplt
  );

  modport slave (
    input  transmit_en, tx_hrst, transwin_en, ifrgap_en,
    output tx_busy, tx_eop_cmplt, tx_sop_rst_cmplt
  );

endinterface

// File: rtl/apb_ucpd_tick_cnt.sv
// Tick-gated saturating counter; done flags the tick on which the count reaches max(limit,1).
module apb_ucpd_tick_cnt
  import apb_ucpd_tx_sched_pkg::*;
#(
  parameter int CNT_W = SCHED_CNT_W
) (
  input  logic             ic_clk,
  input  logic             ic_rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic             hold,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] lim_s;
  logic             en_s;

  // A zero limit behaves as a single tick
  always_comb begin
    lim_s = limit;
    if (limit == {CNT_W{1'b0}}) begin
      lim_s = {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      lim_s = limit;
    end
  end

  assign en_s = tick & ~hold & ~clr;
  assign done = en_s & (({1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, lim_s});

  // Count register: clear wins, then saturating increment
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: arbitrates TXSEND/TXHRST, enforces the bus-idle window and
// interframe gap, and reports status pulses. Optional retry on rx activity: UCPD_TX_RETRY_EN.
module apb_ucpd_tx_sched
  import apb_ucpd_tx_sched_pkg::*;
#(
  parameter int CNT_W     = SCHED_CNT_W,
  parameter int MAX_RETRY = 3
) (
  input  logic                 ic_clk,
  input  logic                 ic_rst_n,
  input  logic                 ucpden,
  input  logic                 ucpd_tick,
  input  logic                 txsend_req,
  input  logic                 txhrst_req,
  input  logic [CNT_W-1:0]     transwin,
  input  logic [CNT_W-1:0]     ifrgap,
  input  logic                 rx_busy,
  apb_ucpd_tx_sched_if.master  tx,
  output logic                 tx_msg_sent,
  output logic                 tx_msg_disc,
  output logic                 tx_msg_abt,
  output logic                 hrst_sent,
  output logic                 hrst_disc,
  output logic                 sched_busy
);

  sched_state_e state_r;
  logic hrst_pend_r;
  logic transmit_en_r, tx_hrst_r, transwin_en_r, ifrgap_en_r;
  logic tx_msg_sent_r, tx_msg_disc_r, tx_msg_abt_r, hrst_sent_r, hrst_disc_r;
  logic win_done_s, gap_done_s, win_clr_s, win_restart_s, tx_cmplt_s;

`ifdef UCPD_TX_RETRY_EN
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);
  logic [1:0] retry_cnt_r;
  logic       rx_busy_d_r;

  // Previous rx_busy, so one receive burst costs exactly one retry
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      rx_busy_d_r <= 1'b0;
    end else begin
      rx_busy_d_r <= rx_busy;
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;
`endif

  assign tx_cmplt_s    = tx.tx_eop_cmplt | tx.tx_sop_rst_cmplt;
  assign win_restart_s = (state_r == SCHED_WIN) & ~hrst_pend_r & txhrst_req & ucpden;
  assign win_clr_s     = (state_r != SCHED_WIN) | rx_busy | win_restart_s;

  apb_ucpd_tick_cnt #(.CNT_W(CNT_W)) u_win_cnt (
    .ic_clk   (ic_clk),
    .ic_rst_n (ic_rst_n),
    .clr      (win_clr_s),
    .tick     (ucpd_tick),
    .hold     (tx.tx_busy),
    .limit    (transwin),
    .done     (win_done_s)
  );

  apb_ucpd_tick_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
    .ic_clk   (ic_clk),
    .ic_rst_n (ic_rst_n),
    .clr      (state_r != SCHED_GAP),
    .tick     (ucpd_tick),
    .hold     (1'b0),
    .limit    (ifrgap),
    .done     (gap_done_s)
  );

  // Scheduler FSM with registered level and pulse outputs
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_r       <= SCHED_IDLE;
      hrst_pend_r   <= 1'b0;
      transmit_en_r <= 1'b0;
      tx_hrst_r     <= 1'b0;
      transwin_en_r <= 1'b0;
      ifrgap_en_r   <= 1'b0;
      tx_msg_sent_r <= 1'b0;
      tx_msg_disc_r <= 1'b0;
      tx_msg_abt_r  <= 1'b0;
      hrst_sent_r   <= 1'b0;
      hrst_disc_r   <= 1'b0;
`ifdef UCPD_TX_RETRY_EN
      retry_cnt_r   <= 2'd0;
`endif
    end else begin
      ifrgap_en_r   <= 1'b0;
      tx_msg_sent_r <= 1'b0;
      tx_msg_disc_r <= 1'b0;
      tx_msg_abt_r  <= 1'b0;
      hrst_sent_r   <= 1'b0;
      hrst_disc_r   <= 1'b0;
      if (!ucpden) begin
        state_r       <= SCHED_IDLE;
        hrst_pend_r   <= 1'b0;
        transmit_en_r <= 1'b0;
        tx_hrst_r     <= 1'b0;
        transwin_en_r <= 1'b0;
        tx_msg_disc_r <= txsend_req | msg_owned(state_r, hrst_pend_r);
        hrst_disc_r   <= txhrst_req | hrst_owned(state_r, hrst_pend_r);
      end else begin
        case (state_r)
          SCHED_IDLE: begin
`ifdef UCPD_TX_RETRY_EN
            retry_cnt_r <= 2'd0;
`endif
            if (txhrst_req || hrst_pend_r) begin
              state_r       <= SCHED_WIN;
              hrst_pend_r   <= 1'b1;
              tx_msg_disc_r <= txsend_req;
            end else if (txsend_req) begin
              state_r     <= SCHED_WIN;
              hrst_pend_r <= 1'b0;
            end else begin
              state_r <= SCHED_IDLE;
            end
          end
          SCHED_WIN: begin
            if (hrst_pend_r) begin
              // A pending hard reset only waits out bus activity
              if (win_done_s) begin
                state_r       <= SCHED_HRST;
                hrst_pend_r   <= 1'b0;
                tx_hrst_r     <= 1'b1;
                transwin_en_r <= 1'b1;
              end
            end else begin
              tx_msg_disc_r <= txsend_req;
              if (txhrst_req) begin
                tx_msg_disc_r <= 1'b1;
                hrst_pend_r   <= 1'b1;
              end
`ifdef UCPD_TX_RETRY_EN
              else if (rx_busy && !rx_busy_d_r) begin
                if (retry_cnt_r >= RETRY_LIM) begin
                  tx_msg_disc_r <= 1'b1;
                  state_r       <= SCHED_IDLE;
                end else begin
                  retry_cnt_r <= retry_cnt_r + 2'd1;
                end
              end
`else
              else if (rx_busy) begin
                tx_msg_disc_r <= 1'b1;
                state_r       <= SCHED_IDLE;
              end
`endif
              else if (win_done_s) begin
                state_r       <= SCHED_MSG;
                transmit_en_r <= 1'b1;
                transwin_en_r <= 1'b1;
              end
            end
          end
          SCHED_MSG: begin
            tx_msg_disc_r <= txsend_req;
            if (tx.tx_busy) begin
              transwin_en_r <= 1'b0;
            end
            if (txhrst_req) begin
              tx_msg_abt_r  <= 1'b1;
              transmit_en_r <= 1'b0;
              tx_hrst_r     <= 1'b1;
              transwin_en_r <= transwin_en_r & ~tx.tx_busy;
              state_r       <= SCHED_HRST;
            end else if (tx_cmplt_s) begin
              tx_msg_sent_r <= 1'b1;
              transmit_en_r <= 1'b0;
              transwin_en_r <= 1'b0;
              state_r       <= SCHED_GAP;
            end
          end
          SCHED_HRST: begin
            tx_msg_disc_r <= txsend_req;
            if (tx.tx_busy) begin
              transwin_en_r <= 1'b0;
            end
            if (tx_cmplt_s) begin
              hrst_sent_r   <= 1'b1;
              tx_hrst_r     <= 1'b0;
              transwin_en_r <= 1'b0;
              state_r       <= SCHED_GAP;
            end
          end
          SCHED_GAP: begin
            tx_msg_disc_r <= txsend_req;
            if (txhrst_req) begin
              hrst_pend_r <= 1'b1;
            end
            if (gap_done_s) begin
              ifrgap_en_r <= 1'b1;
              state_r     <= SCHED_IDLE;
            end
          end
          default: begin
            state_r       <= SCHED_IDLE;
            hrst_pend_r   <= 1'b0;
            transmit_en_r <= 1'b0;
            tx_hrst_r     <= 1'b0;
            transwin_en_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx.transmit_en = transmit_en_r;
  assign tx.tx_hrst     = tx_hrst_r;
  assign tx.transwin_en = transwin_en_r;
  assign tx.ifrgap_en   = ifrgap_en_r;
  assign tx_msg_sent    = tx_msg_sent_r;
  assign tx_msg_disc    = tx_msg_disc_r;
  assign tx_msg_abt     = tx_msg_abt_r;
  assign hrst_sent      = hrst_sent_r;
  assign hrst_disc      = hrst_disc_r;
  assign sched_busy     = (state_r != SCHED_IDLE);

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Directed self-checking bench for apb_ucpd_tx_sched (default build, retry disabled).
module tb_apb_ucpd_tx_sched;

  logic       ic_clk = 1'b0;
  logic       ic_rst_n;
  logic       ucpden, ucpd_tick, txsend_req, txhrst_req, rx_busy;
  logic [4:0] transwin, ifrgap;
  logic       tx_msg_sent, tx_msg_disc, tx_msg_abt, hrst_sent, hrst_disc, sched_busy;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  apb_ucpd_tx_sched_if txif ();

  apb_ucpd_tx_sched #(.CNT_W(5), .MAX_RETRY(3)) dut (
    .ic_clk      (ic_clk),
    .ic_rst_n    (ic_rst_n),
    .ucpden      (ucpden),
    .ucpd_tick   (ucpd_tick),
    .txsend_req  (txsend_req),
    .txhrst_req  (txhrst_req),
    .transwin    (transwin),
    .ifrgap      (ifrgap),
    .rx_busy     (rx_busy),
    .tx          (txif.master),
    .tx_msg_sent (tx_msg_sent),
    .tx_msg_disc (tx_msg_disc),
    .tx_msg_abt  (tx_msg_abt),
    .hrst_sent   (hrst_sent),
    .hrst_disc   (hrst_disc),
    .sched_busy  (sched_busy)
  );

  always #5 ic_clk = ~ic_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ic_clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      ucpd_tick = 1'b1;
      @(negedge ic_clk);
      ucpd_tick = 1'b0;
    end
  endtask

  // {transmit_en, tx_hrst, transwin_en, ifrgap_en, sched_busy}
  function automatic logic [4:0] lv();
    return {txif.transmit_en, txif.tx_hrst, txif.transwin_en, txif.ifrgap_en, sched_busy};
  endfunction

  // {tx_msg_sent, tx_msg_disc, tx_msg_abt, hrst_sent, hrst_disc}
  function automatic logic [4:0] pl();
    return {tx_msg_sent, tx_msg_disc, tx_msg_abt, hrst_sent, hrst_disc};
  endfunction

  initial begin
    ic_rst_n = 1'b0; ucpden = 1'b0; ucpd_tick = 1'b0; txsend_req = 1'b0;
    txhrst_req = 1'b0; rx_busy = 1'b0; transwin = 5'd4; ifrgap = 5'd2;
    txif.tx_busy = 1'b0; txif.tx_eop_cmplt = 1'b0; txif.tx_sop_rst_cmplt = 1'b0;
    cyc(2);
    chk("reset_levels", lv(), 5'b00000);
    chk("reset_pulses", pl(), 5'b00000);
    ic_rst_n = 1'b1;
    cyc(1);

    // Request while disabled is dropped with a discard pulse
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    chk("dis_send_disc", pl(), 5'b01000);
    chk("dis_send_idle", lv(), 5'b00000);
    ucpden = 1'b1;
    cyc(1);

    // Normal message: window of 4 ticks, gap of 2 ticks
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    chk("msg_win_entry", lv(), 5'b00001);
    tick(3);
    chk("msg_win_3ticks", lv(), 5'b00001);
    tick(1);
    chk("msg_win_open", lv(), 5'b10101);
    txif.tx_busy = 1'b1; cyc(1);
    chk("msg_transwin_drop", lv(), 5'b10001);
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    chk("msg_send_ignored", pl(), 5'b01000);
    txif.tx_eop_cmplt = 1'b1; cyc(1); txif.tx_eop_cmplt = 1'b0; txif.tx_busy = 1'b0;
    chk("msg_sent", pl(), 5'b10000);
    chk("msg_gap_levels", lv(), 5'b00001);
    cyc(1);
    chk("msg_sent_single", pl(), 5'b00000);
    tick(1);
    chk("gap_1tick", lv(), 5'b00001);
    tick(1);
    chk("gap_done", lv(), 5'b00010);
    cyc(1);
    chk("gap_pulse_single", lv(), 5'b00000);

    // Receiver activity during the window discards the message
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    tick(2);
    rx_busy = 1'b1; cyc(1); rx_busy = 1'b0;
    chk("rx_disc_pulse", pl(), 5'b01000);
    chk("rx_disc_idle", lv(), 5'b00000);
    tick(5);
    chk("rx_disc_no_tx", lv(), 5'b00000);

    // Hard reset aborts an active message
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    tick(4);
    txif.tx_busy = 1'b1; cyc(1);
    txhrst_req = 1'b1; cyc(1); txhrst_req = 1'b0;
    chk("abt_pulse", pl(), 5'b00100);
    chk("abt_levels", lv(), 5'b01001);
    txif.tx_sop_rst_cmplt = 1'b1; cyc(1); txif.tx_sop_rst_cmplt = 1'b0; txif.tx_busy = 1'b0;
    chk("abt_hrst_sent", pl(), 5'b00010);
    chk("abt_gap_levels", lv(), 5'b00001);
    tick(2);
    chk("abt_gap_done", lv(), 5'b00010);

    // Simultaneous send and hard reset: message discarded, hard reset proceeds
    txsend_req = 1'b1; txhrst_req = 1'b1; cyc(1); txsend_req = 1'b0; txhrst_req = 1'b0;
    chk("both_disc", pl(), 5'b01000);
    rx_busy = 1'b1; tick(2); rx_busy = 1'b0;
    chk("both_rx_keeps_hrst", {pl(), lv()}, 10'b00000_00001);
    tick(4);
    chk("both_hrst_open", lv(), 5'b01101);
    txif.tx_busy = 1'b1; cyc(1);
    chk("both_transwin_drop", lv(), 5'b01001);
    txif.tx_sop_rst_cmplt = 1'b1; cyc(1); txif.tx_sop_rst_cmplt = 1'b0; txif.tx_busy = 1'b0;
    chk("both_hrst_sent", pl(), 5'b00010);
    tick(2);
    cyc(1);

    // Disable during hard reset
    txhrst_req = 1'b1; cyc(1); txhrst_req = 1'b0;
    tick(4);
    chk("dis_hrst_active", lv(), 5'b01101);
    ucpden = 1'b0; cyc(1);
    chk("dis_hrst_disc", pl(), 5'b00001);
    chk("dis_hrst_levels", lv(), 5'b00000);
    ucpden = 1'b1; cyc(1);

    // Zero window/gap behave as one tick
    transwin = 5'd0; ifrgap = 5'd0;
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    tick(1);
    chk("zero_win_1tick", lv(), 5'b10101);
    txif.tx_eop_cmplt = 1'b1; cyc(1); txif.tx_eop_cmplt = 1'b0;
    chk("zero_sent", pl(), 5'b10000);
    tick(1);
    chk("zero_gap_1tick", lv(), 5'b00010);
    cyc(1);

    // Asynchronous reset in the middle of a message
    txsend_req = 1'b1; cyc(1); txsend_req = 1'b0;
    tick(1);
    chk("arst_pre_msg", lv(), 5'b10101);
    #2 ic_rst_n = 1'b0;
    #1 chk("arst_levels", lv(), 5'b00000);
    cyc(1);
    ic_rst_n = 1'b1;
    cyc(1);
    chk("arst_stays_idle", lv(), 5'b00000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_ucpd_tx_sched.md
Name: apb_ucpd_tx_sched

Overview:
Transmit scheduler/arbiter sitting between the APB register block (TXSEND/TXHRST commands) and the PD main TX state machine.
- Arbitrates between SW message requests and hard-reset requests (hard reset has priority).
- Enforces the pre-transmit bus-idle window; generates transmit_en/tx_hrst/transwin_en.
- Times the interframe gap and issues ifrgap_en.
- Reports sent/discarded status pulses to the interrupt logic.

Parameters:
CNT_W, 5, width of the window and gap counters and of the transwin/ifrgap config inputs.
MAX_RETRY, 3, retry limit; used only with UCPD_TX_RETRY_EN.

Ports:
ic_clk  in  1  usbpd kernel clock.
ic_rst_n  in  1  async active-low reset.
ucpden  in  1  peripheral enable.
ucpd_tick  in  1  one-cycle ic_clk pulse per ucpd_clk period; time base for all counters.
txsend_req  in  1  pulse: SW TXSEND command.
txhrst_req  in  1  pulse: SW TXHRST command.
transwin  in  CNT_W  bus-idle window length in ticks; 0 is treated as 1.
ifrgap  in  CNT_W  interframe gap length in ticks; 0 is treated as 1.
rx_busy  in  1  receiver is not idle (rx FSM outside RX_IDLE).
tx_busy  in  1  TX FSM is outside TX_IDLE.
tx_eop_cmplt  in  1  pulse: EOP fully sent.
tx_sop_rst_cmplt  in  1  pulse: reset ordered set sent.
transmit_en  out  1  level: message transmission requested.
tx_hrst  out  1  level: hard reset requested or in progress.
transwin_en  out  1  level: transmit window open; TX FSM may leave idle.
ifrgap_en  out  1  pulse: interframe gap elapsed.
tx_msg_sent  out  1  pulse.
tx_msg_disc  out  1  pulse.
tx_msg_abt  out  1  pulse: message aborted by hard reset.
hrst_sent  out  1  pulse.
hrst_disc  out  1  pulse.
sched_busy  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE, all counters 0, all outputs 0.
- States: IDLE, WIN, MSG, HRST, GAP.
- IDLE:
  - txhrst_req & ucpden -> WIN with hrst_pend=1. If txsend_req arrives in the same cycle, tx_msg_disc pulses next cycle.
  - txsend_req & ucpden -> WIN with hrst_pend=0.
  - Request while ucpden=0 -> dropped, with the matching disc pulse.
- WIN:
  - win_cnt increments on ucpd_tick while rx_busy=0 and tx_busy=0.
  - rx_busy=1 clears win_cnt.
  - rx_busy=1 with a message pending -> tx_msg_disc pulse, go to IDLE.
  - Hard reset pending -> keep waiting; never discarded by rx activity.
  - win_cnt reaches max(transwin,1) on a tick -> go to HRST if hrst_pend, else MSG.
  - txhrst_req while a message is pending -> tx_msg_disc pulse, set hrst_pend, restart win_cnt.
- MSG:
  - transmit_en=1.
  - transwin_en=1 from entry until the first cycle tx_busy=1, then 0.
  - tx_eop_cmplt or tx_sop_rst_cmplt -> tx_msg_sent pulse, go to GAP.
  - txhrst_req -> tx_msg_abt pulse, transmit_en drops, go to HRST; transwin_en stays 0 because the FSM is already active.
- HRST:
  - tx_hrst=1; transwin_en follows the same rule as MSG.
  - tx_eop_cmplt or tx_sop_rst_cmplt -> hrst_sent pulse, tx_hrst drops, go to GAP.
- GAP:
  - gap_cnt counts ticks up to max(ifrgap,1).
  - On reaching it: ifrgap_en pulses for 1 cycle, go to IDLE.
  - txhrst_req during GAP -> latch hrst_pend; take it in IDLE the cycle after the gap ends.
- txsend_req outside IDLE (and not in WIN-with-hrst): ignored, tx_msg_disc pulse.
- ucpden falling in any state:
  - Next cycle: state IDLE, all level outputs 0, counters cleared.
  - Pending or active message -> tx_msg_disc; pending or active hard reset -> hrst_disc. Both may pulse together.
- Status pulses are single-cycle and registered: they assert 1 cycle after the causing event.
- Counters saturate and never wrap; width is CNT_W, compared against the config inputs sampled live.

Optional Feature:
UCPD_TX_RETRY_EN.
- Defined:
  - rx_busy during WIN with a message pending returns to WIN start (win_cnt=0) and increments a 2-bit retry_cnt.
  - tx_msg_disc pulses only when retry_cnt would exceed MAX_RETRY.
  - retry_cnt clears on IDLE entry.
- Undefined: immediate discard as above; retry_cnt does not exist.

Decomposition:
- Shared package/include: state encodings SCHED_IDLE..SCHED_GAP (3-bit) and the CNT_W default, alongside the existing PRE/SOP/CRC bit-count defines.
- One sub-module: apb_ucpd_tick_cnt, a tick-gated saturating counter with clear and done compare, instantiated twice (window and gap).

Test Plan:
- transwin=4, ifrgap=2, txsend_req, idle bus -> transwin_en after 4 ticks; drive tx_busy, then tx_eop_cmplt -> tx_msg_sent; ifrgap_en exactly 2 ticks later; IDLE.
- txsend_req, rx_busy=1 at tick 2 of WIN -> tx_msg_disc, no transmit_en ever. With UCPD_TX_RETRY_EN: 3 retries, discard on the 4th.
- txhrst_req in MSG after tx_busy=1 -> tx_msg_abt, tx_hrst=1, transmit_en=0; tx_sop_rst_cmplt -> hrst_sent, then GAP.
- txsend_req and txhrst_req in the same cycle -> tx_msg_disc, HRST path, hrst_sent.
- ucpden=0 during HRST -> hrst_disc, all outputs 0 next cycle.
- transwin=0, ifrgap=0 -> each behaves as 1 tick; async reset mid-MSG -> all outputs 0 immediately.
